if_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the ID stage (decoder, register-file read, immediate generator).

---
 rtl/if_fetch_stage.sv | 139 +++++++++++++
 tb/tb_if_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one outstanding imem read at a time, registered ID slot plus a
// one-entry skid buffer, and redirect that squashes anything in flight.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [1:0]  dbg_state_o
);

    // Encoding is visible on dbg_state_o: 0 FETCH, 1 WAIT, 2 HOLD, 3 DRAIN.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic        drain;
    logic [31:0] redirect_target;

    // Valid/ready: a transfer happens on any cycle where valid and ready are both high;
    // a valid source holds its payload stable until that cycle.
    assign drain           = id_valid_q & id_ready;
    assign redirect_target = redirect_pc & ~32'h0000_0003;

    assign imem_req_valid = (state_q == S_FETCH) & ~redirect_valid & ~rst;
    assign imem_req_addr  = fetch_pc_q;
    assign id_valid       = id_valid_q;
    assign instruction    = instr_q;
    assign pc             = pc_q;
    assign dbg_state_o    = state_q;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        id_valid_d   = id_valid_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (drain) begin
            id_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
        end

        case (state_q)
            S_FETCH: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (!id_valid_q || drain) begin
                        id_valid_d = 1'b1;
                        pc_d       = fetch_pc_q;
                        instr_d    = imem_resp_data;
                        state_d    = S_FETCH;
                    end else begin
                        skid_pc_d    = fetch_pc_q;
                        skid_instr_d = imem_resp_data;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // The skid is occupied exactly while in HOLD.
                if (drain) begin
                    id_valid_d = 1'b1;
                    pc_d       = skid_pc_q;
                    instr_d    = skid_instr_q;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Redirect overrides everything above; a response arriving in the same cycle is dropped.
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            id_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_resp_valid) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            fetch_pc_q   <= RESET_PC;
            id_valid_q   <= 1'b0;
            pc_q         <= 32'h0000_0000;
            instr_q      <= NOP_INSTR;
            skid_pc_q    <= 32'h0000_0000;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            id_valid_q   <= id_valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run, checked against an
// in-order delivery model (next expected pc, memory word as a function of address).
module tb_if_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC1 = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req_valid,  imem_req_valid2;
    logic [31:0] imem_req_addr,   imem_req_addr2;
    logic        id_valid,        id_valid2;
    logic [31:0] instruction,     instruction2;
    logic [31:0] pc,              pc2;
    logic [1:0]  dbg_state,       dbg_state2;

    if_fetch_stage #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .instruction(instruction), .pc(pc), .dbg_state_o(dbg_state)
    );

    // Shares every input with u_dut; its control flow is address independent, so it runs in lockstep.
    if_fetch_stage #(.RESET_PC(RPC2), .NOP_INSTR(NOP)) u_dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr2), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid2), .id_ready(id_ready),
        .instruction(instruction2), .pc(pc2), .dbg_state_o(dbg_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests_run = 0;
    int          failed    = 0;
    int          n_fires   = 0;
    logic [31:0] exp_pc, exp_pc2;
    logic        pend;
    int          pend_delay;
    logic [31:0] pend_addr;
    int          resp_min, resp_max;
    logic        hold_prev;
    logic [31:0] prev_pc, prev_instr;
    logic        s_req_valid, s_id_valid, s_id_valid2;
    logic [31:0] s_req_addr, s_req_addr2, s_pc, s_pc2, s_instr;
    logic [1:0]  s_state;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive imem response, sample at negedge, check, update model, advance.
    task automatic step();
        logic drove, rf, idf, idf2;
        drove = pend && (pend_delay == 0) && !rst;
        imem_resp_valid = drove;
        imem_resp_data  = drove ? mem_word(pend_addr) : $urandom();
        @(negedge clk);
        s_req_valid = imem_req_valid;  s_req_addr  = imem_req_addr;  s_req_addr2 = imem_req_addr2;
        s_id_valid  = id_valid;        s_id_valid2 = id_valid2;
        s_pc        = pc;              s_pc2       = pc2;
        s_instr     = instruction;     s_state     = dbg_state;
        rf   = imem_req_valid & imem_req_ready;
        idf  = id_valid & id_ready;
        idf2 = id_valid2 & id_ready;

        check("req_align", {30'b0, imem_req_addr[1:0]}, 32'h0);
        if (rst || redirect_valid) check("req_quiet", {31'b0, imem_req_valid}, 32'h0);
        if (!id_valid) check("nop_idle", instruction, NOP);
        if (hold_prev) begin
            check("hold_valid", {31'b0, id_valid}, 32'h1);
            check("hold_pc", pc, prev_pc);
            check("hold_instr", instruction, prev_instr);
        end
        if (idf) begin
            check("id_pc", pc, exp_pc);
            check("id_instr", instruction, mem_word(exp_pc));
        end
        if (idf2) check("id2_pc", pc2, exp_pc2);
        if (rf) check("one_outstanding", {31'b0, pend & ~drove}, 32'h0);

        hold_prev  = id_valid & ~id_ready & ~redirect_valid & ~rst;
        prev_pc    = pc;
        prev_instr = instruction;
        if (rst) begin
            exp_pc  = RPC1;
            exp_pc2 = RPC2;
            pend    = 1'b0;
        end else begin
            if (idf) begin
                exp_pc = exp_pc + 32'd4;
                n_fires++;
            end
            if (idf2) exp_pc2 = exp_pc2 + 32'd4;
            if (redirect_valid) begin
                exp_pc  = redirect_pc & ~32'h3;
                exp_pc2 = redirect_pc & ~32'h3;
            end
            if (drove) pend = 1'b0;
            else if (pend) pend_delay--;
            if (rf) begin
                pend       = 1'b1;
                pend_addr  = imem_req_addr;
                pend_delay = $urandom_range(resp_max, resp_min);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int f0;
        rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        pend = 1'b0; pend_delay = 0; pend_addr = 32'h0; resp_min = 0; resp_max = 0;
        hold_prev = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
        exp_pc = RPC1; exp_pc2 = RPC2;

        // Reset state and streaming throughput
        do_reset();
        check("rst_id_valid", {31'b0, s_id_valid}, 32'h0);
        check("rst_instr", s_instr, NOP);
        check("rst_pc", s_pc, 32'h0);
        check("rst_state", {30'b0, s_state}, 32'h0);
        check("rst_req_valid", {31'b0, s_req_valid}, 32'h0);
        f0 = n_fires;
        step();
        check("t1_req_valid", {31'b0, s_req_valid}, 32'h1);
        check("t1_req_addr", s_req_addr, RPC1);
        step();
        check("t1_wait_state", {30'b0, s_state}, 32'h1);
        check("t1_not_yet_valid", {31'b0, s_id_valid}, 32'h0);
        step();
        check("t1_first_valid", {31'b0, s_id_valid}, 32'h1);
        check("t1_first_pc", s_pc, 32'h0);
        for (int i = 0; i < 17; i++) step();
        check("t1_throughput", n_fires - f0, 9);

        // Backpressure: slot + skid fill, HOLD, then resume
        do_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t2_state_hold", {30'b0, s_state}, 32'h2);
        check("t2_no_req", {31'b0, s_req_valid}, 32'h0);
        check("t2_slot_pc", s_pc, 32'h0);
        step();
        step();
        check("t2_still_no_req", {31'b0, s_req_valid}, 32'h0);
        id_ready = 1'b1;
        step();
        step();
        check("t2_skid_pc", s_pc, 32'h4);
        check("t2_skid_valid", {31'b0, s_id_valid}, 32'h1);
        check("t2_resume_state", {30'b0, s_state}, 32'h0);
        check("t2_resume_addr", s_req_addr, 32'h8);
        for (int i = 0; i < 4; i++) step();

        // Redirect while waiting on a slow response
        do_reset();
        resp_min = 2; resp_max = 2;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        check("t3_redir_no_req", {31'b0, s_req_valid}, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("t3_drain_state", {30'b0, s_state}, 32'h3);
        check("t3_drain_idv", {31'b0, s_id_valid}, 32'h0);
        step();
        check("t3_drain_resp_state", {30'b0, s_state}, 32'h3);
        check("t3_drain_resp_idv", {31'b0, s_id_valid}, 32'h0);
        step();
        check("t3_refetch_state", {30'b0, s_state}, 32'h0);
        check("t3_refetch_valid", {31'b0, s_req_valid}, 32'h1);
        check("t3_refetch_addr", s_req_addr, 32'h0000_0100);
        check("t3_refetch_idv", {31'b0, s_id_valid}, 32'h0);
        resp_min = 0; resp_max = 0;
        f0 = n_fires;
        for (int i = 0; i < 7; i++) step();
        check("t3_progress", {31'b0, (n_fires - f0) >= 2}, 32'h1);

        // Redirect coinciding with the response
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        step();
        check("t4_state_fetch", {30'b0, s_state}, 32'h0);
        check("t4_req_valid", {31'b0, s_req_valid}, 32'h1);
        check("t4_req_addr", s_req_addr, 32'h0000_0200);
        check("t4_idv", {31'b0, s_id_valid}, 32'h0);
        for (int i = 0; i < 4; i++) step();

        // Wrap of fetch address from RESET_PC near the top of the space
        do_reset();
        step();
        check("t5_req_addr0", s_req_addr2, RPC2);
        step();
        step();
        check("t5_pc0", s_pc2, 32'hFFFF_FFF8);
        check("t5_v0", {31'b0, s_id_valid2}, 32'h1);
        step();
        step();
        check("t5_pc1", s_pc2, 32'hFFFF_FFFC);
        check("t5_req_wrap", s_req_addr2, 32'h0000_0000);
        step();
        step();
        check("t5_pc2", s_pc2, 32'h0000_0000);

        // Reset while holding a full skid
        do_reset();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_in_hold", {30'b0, s_state}, 32'h2);
        rst = 1'b1;
        step();
        check("t6_rst_no_req", {31'b0, s_req_valid}, 32'h0);
        rst = 1'b0;
        step();
        check("t6_idv", {31'b0, s_id_valid}, 32'h0);
        check("t6_state", {30'b0, s_state}, 32'h0);
        check("t6_req_valid", {31'b0, s_req_valid}, 32'h1);
        check("t6_req_addr", s_req_addr, RPC1);
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic
        resp_min = 0; resp_max = 3;
        f0 = n_fires;
        for (int i = 0; i < 800; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            id_ready       = ($urandom_range(2, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = $urandom();
            if ($urandom_range(1, 0) == 1) redirect_pc = 32'hFFFF_FFF0 | {28'h0, redirect_pc[3:0]};
            rst            = ($urandom_range(199, 0) == 0);
            step();
        end
        check("rand_progress", {31'b0, (n_fires - f0) >= 50}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
